// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted through a
// valid/ready handshake and shifted out one bit per clock, LSB first or MSB
// first according to the mode latched with the word. The last-bit cycle can
// accept the next word, so consecutive frames run with no idle cycle.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   data_in     parallel word, sampled only when a load is accepted
//   mode        bit order, sampled with data_in (1 = LSB first, 0 = MSB first)
//   load_valid  data_in / mode are valid
//   load_ready  a word can be accepted this cycle
//   sout        serial data bit
//   sout_valid  sout carries a frame bit this cycle
//   sout_last   the current bit is the final bit of the frame
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic             dir_q,   dir_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic at_last;
  logic accept;

  // ---------------------------------------------------------------------------
  // Next-state and output decode. All outputs come from registered state only,
  // so load_ready never depends on load_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise any path
    // that skips an assignment infers a latch.
    state_d    = state_q;
    sreg_d     = sreg_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;

    at_last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    load_ready = (state_q == IDLE) || at_last;
    accept     = load_valid && load_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = data_in;
          dir_d   = mode;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // The output end of the register is bit 0 for LSB-first, bit WIDTH-1
        // for MSB-first; shifting moves the next bit into that position.
        sout       = dir_q ? sreg_q[0] : sreg_q[WIDTH-1];
        sout_valid = 1'b1;
        sout_last  = at_last;

        if (!at_last) begin
          sreg_d = dir_q ? (sreg_q >> 1) : (sreg_q << 1);
          cnt_d  = cnt_q + CW'(1);
        end else if (accept) begin
          // Reload during the last bit: the next frame starts on the next
          // cycle without a gap.
          sreg_d  = data_in;
          dir_d   = mode;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers with synchronous reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values from
    // before this edge, independent of statement order.
    if (reset) begin
      // NOTE: the shift register is cleared too, so a frame aborted by reset
      // leaves no stale data behind.
      state_q <= IDLE;
      sreg_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Self-checking bench for piso_serializer (WIDTH = 4). Directed frames from the
// block's behaviour list are followed by a randomized run. The reference model
// is a queue of pending serial bits: the head is the bit on the line this
// cycle, and an accepted word pushes its WIDTH bits in transmit order.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] data_in;
  logic         mode;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_last;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .mode       (mode),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic l;
  } ser_bit_t;

  ser_bit_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Receivers fed from the observed line: shift-left for MSB-first frames,
  // shift-right for LSB-first frames.
  logic [7:0]   rx_msb;
  logic [W-1:0] rx_lsb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_valid, e_sout, e_last, e_ready;
    e_valid = (exp_q.size() > 0);
    e_sout  = e_valid ? exp_q[0].b : 1'b0;
    e_last  = e_valid ? exp_q[0].l : 1'b0;
    // A new word fits once at most the current (final) bit is pending.
    e_ready = (exp_q.size() <= 1);
    check("sout",       {31'd0, sout},       {31'd0, e_sout});
    check("sout_valid", {31'd0, sout_valid}, {31'd0, e_valid});
    check("sout_last",  {31'd0, sout_last},  {31'd0, e_last});
    check("load_ready", {31'd0, load_ready}, {31'd0, e_ready});
    if (sout_valid === 1'b1) begin
      rx_msb = {rx_msb[6:0], sout};
      rx_lsb = {sout, rx_lsb[W-1:1]};
    end
  endtask

  task automatic model_edge(input logic r, input logic lv, input logic [W-1:0] d, input logic m);
    logic rdy;
    ser_bit_t sb;
    rdy = (exp_q.size() <= 1);
    if (r) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (lv && rdy) begin
        for (int k = 0; k < W; k++) begin
          sb.b = m ? d[k] : d[W-1-k];
          sb.l = (k == W - 1);
          exp_q.push_back(sb);
        end
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, check outputs, then let
  // the rising edge happen and advance the model.
  task automatic tick(input logic r, input logic lv, input logic [W-1:0] d, input logic m);
    reset      = r;
    load_valid = lv;
    data_in    = d;
    mode       = m;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(r, lv, d, m);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    data_in    = '0;
    mode       = 1'b0;
    rx_msb     = '0;
    rx_lsb     = '0;

    // Reset for two cycles, then idle with nothing offered.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, 1'b0);

    // MSB-first frame of 1011: line carries 1,0,1,1.
    rx_msb = '0;
    tick(1'b0, 1'b1, 4'b1011, 1'b0);
    for (int i = 0; i < W; i++) tick(1'b0, 1'b0, '0, 1'b0);
    check("msb_rx_word", {28'd0, rx_msb[3:0]}, 32'hB);
    tick(1'b0, 1'b0, '0, 1'b0);

    // LSB-first frame of 1011: a shift-right receiver rebuilds 1011.
    rx_lsb = '0;
    tick(1'b0, 1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < W; i++) tick(1'b0, 1'b0, '0, 1'b0);
    check("lsb_rx_word", {28'd0, rx_lsb}, 32'hB);
    tick(1'b0, 1'b0, '0, 1'b0);

    // Back-to-back: 1100 then 0011 with load_valid held until accepted.
    rx_msb = '0;
    tick(1'b0, 1'b1, 4'b1100, 1'b0);
    for (int i = 0; i < W; i++) tick(1'b0, 1'b1, 4'b0011, 1'b0);
    for (int i = 0; i < W; i++) tick(1'b0, 1'b0, '0, 1'b0);
    check("b2b_rx_bits", {24'd0, rx_msb}, 32'hC3);
    tick(1'b0, 1'b0, '0, 1'b0);

    // Mid-frame input changes: 0110 MSB-first, other data/mode offered during
    // bits 1-3 must neither alter the frame nor be accepted early.
    rx_msb = '0;
    tick(1'b0, 1'b1, 4'b0110, 1'b0);
    for (int i = 0; i < W - 1; i++) tick(1'b0, 1'b1, 4'b1001, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b0);
    check("midframe_rx_word", {28'd0, rx_msb[3:0]}, 32'h6);
    tick(1'b0, 1'b0, '0, 1'b0);

    // Reset during bit 2 of 1111, with a load offered in the reset cycle.
    tick(1'b0, 1'b1, 4'b1111, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b1, 4'b0101, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b0);
    rx_lsb = '0;
    tick(1'b0, 1'b1, 4'b1000, 1'b1);
    for (int i = 0; i < W; i++) tick(1'b0, 1'b0, '0, 1'b0);
    check("post_reset_rx_word", {28'd0, rx_lsb}, 32'h8);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           W'($urandom),
           1'($urandom));
    end

    // Drain so the line returns to idle.
    for (int i = 0; i < W + 2; i++) tick(1'b0, 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
